// File: rtl/psum_drain_unit.sv
// psum_drain_unit
// Drains one 16-row job of 20-bit signed partial sums from a shift FIFO,
// quantizes every lane to 8-bit signed (arithmetic right shift, floor,
// saturate) and streams the rows out over a valid/ready interface.
// The first row is captured in the start cycle, so the FIFO is always one
// row ahead of the output register and the last fifo_en pulse happens
// when row 15 is captured, not when it is accepted.
module psum_drain_unit (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   shift_amt,
    input  logic [319:0] fifo_dout,
    output logic         fifo_en,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_last,
    output logic         busy,
    output logic         done
);

    localparam int ROWS  = 16;
    localparam int LANES = 16;
    localparam int IN_W  = 20;
    localparam int OUT_W = 8;

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    // Saturation bounds expressed in the pre-quantization width
    localparam logic signed [IN_W-1:0] Y_MAX = 20'sd127;
    localparam logic signed [IN_W-1:0] Y_MIN = -20'sd128;
    localparam logic [OUT_W-1:0]       OUT_MAX = 8'h7F;
    localparam logic [OUT_W-1:0]       OUT_MIN = 8'h80;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               shift_q, shift_d;
    logic [LANES*OUT_W-1:0]   data_q, data_d;
    logic                     done_q, done_d;
    logic                     fifo_en_c;

    // The start cycle has not latched the shift yet, so use the live input
    logic [3:0]               sh_sel;
    logic [LANES*OUT_W-1:0]   q_row;

    assign sh_sel = (state_q == IDLE) ? shift_amt : shift_q;

    // Per-lane quantizer: independent lanes, no carry between them
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [IN_W-1:0] lane_x;
            logic signed [IN_W-1:0] lane_y;

            assign lane_x = fifo_dout[gi*IN_W +: IN_W];
            assign lane_y = lane_x >>> sh_sel;

            // Clamp the shifted value into the signed 8-bit range
            always_comb begin
                if (lane_y > Y_MAX) begin
                    q_row[gi*OUT_W +: OUT_W] = OUT_MAX;
                end else if (lane_y < Y_MIN) begin
                    q_row[gi*OUT_W +: OUT_W] = OUT_MIN;
                end else begin
                    q_row[gi*OUT_W +: OUT_W] = lane_y[OUT_W-1:0];
                end
            end
        end
    endgenerate

    // Next-state logic: hold everything unless a start or handshake occurs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        fifo_en_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    cnt_d     = 4'd0;
                    shift_d   = shift_amt;
                    data_d    = q_row;
                    fifo_en_c = 1'b1;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        data_d    = q_row;
                        fifo_en_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 4'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Never advance the FIFO while reset is asserted
    assign fifo_en = fifo_en_c & reset_n;
    assign m_valid = (state_q == SEND);
    assign m_last  = (state_q == SEND) && (cnt_q == LAST_ROW);
    assign busy    = (state_q != IDLE);
    assign m_data  = data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_psum_drain_unit.sv
// Testbench for psum_drain_unit: FIFO model driven from a row array, a
// floor-division reference quantizer, and one task per scenario.
module tb_psum_drain_unit;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   shift_amt;
    logic [319:0] fifo_dout;
    logic         fifo_en;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    psum_drain_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .shift_amt (shift_amt),
        .fifo_dout (fifo_dout),
        .fifo_en   (fifo_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // FIFO model: head row is indexed by pulses seen since the job base
    logic [319:0] fifo_mem [0:15];
    int en_total = 0;
    int base     = 0;

    always @(posedge clk) begin
        if (fifo_en === 1'b1) en_total <= en_total + 1;
    end

    always_comb begin
        fifo_dout = '0;
        if ((en_total - base) >= 0 && (en_total - base) < 16)
            fifo_dout = fifo_mem[en_total - base];
    end

    int checks = 0;
    int errors = 0;

    // Observations of the most recent job
    logic [127:0] obs_data [0:15];
    bit           obs_last [0:15];
    int obs_n, en_count, en_bad, stall_viol, done_count, valid_cycles;
    bit done_next, valid_after, timeout;

    // Reference quantizer: floor division by 2^sh, then clamp to int8
    function automatic logic [127:0] model_row(input logic [319:0] row, input int sh);
        logic [127:0] r;
        logic [19:0]  lane;
        int x, d, q;
        r = '0;
        for (int l = 0; l < 16; l++) begin
            lane = row[20*l +: 20];
            x = int'(lane);
            if (lane[19]) x = x - (1 << 20);
            d = 1 << sh;
            q = x / d;
            if ((x % d) != 0 && x < 0) q = q - 1;
            if (q > 127) q = 127;
            else if (q < -128) q = -128;
            r[8*l +: 8] = q[7:0];
        end
        return r;
    endfunction

    task automatic fill_random();
        logic [19:0] v;
        for (int r = 0; r < 16; r++) begin
            for (int l = 0; l < 16; l++) begin
                case ($urandom_range(0, 3))
                    0: v = 20'($urandom_range(0, 1023)) - 20'd512;
                    1: v = 20'($urandom);
                    2: v = 20'($urandom_range(0, 65535)) - 20'd32768;
                    default: v = $urandom_range(0, 1) ? 20'h7FFFF : 20'h80000;
                endcase
                fifo_mem[r][20*l +: 20] = v;
            end
        end
    endtask

    // Runs one job: mode 0 = ready held, 1 = ready 1,0,0 pattern, 2 = random.
    // Stops after stop_hs handshakes; for full jobs also samples two cycles after.
    task automatic run_job(input int sh, input int mode, input int busy_row,
                           input int busy_sh, input int stop_hs);
        int hs, cyc;
        logic [127:0] prev_data;
        bit prev_stall, busy_pulsed;
        obs_n = 0; en_count = 0; en_bad = 0; stall_viol = 0; done_count = 0;
        valid_cycles = 0; done_next = 0; valid_after = 1; timeout = 0;
        prev_data = '0;
        @(negedge clk);
        base = en_total;
        start = 1'b1;
        shift_amt = sh[3:0];
        m_ready = 1'b0;
        #1;
        if (fifo_en === 1'b1) en_count++;
        if (done === 1'b1) done_count++;
        @(negedge clk);
        start = 1'b0;
        shift_amt = 4'($urandom);
        hs = 0; cyc = 0; prev_stall = 0; busy_pulsed = 0;
        while (hs < stop_hs && cyc < 400) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy_row >= 0 && hs == busy_row && !busy_pulsed) begin
                start = 1'b1;
                shift_amt = busy_sh[3:0];
                busy_pulsed = 1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done === 1'b1) done_count++;
            if (prev_stall && m_data !== prev_data) stall_viol++;
            if (fifo_en === 1'b1) begin
                en_count++;
                if (!(m_valid === 1'b1 && m_ready && hs != 15)) en_bad++;
            end
            if (m_valid === 1'b1) valid_cycles++;
            if (m_valid === 1'b1 && m_ready) begin
                obs_data[hs] = m_data;
                obs_last[hs] = m_last;
                hs++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 400) timeout = 1;
        obs_n = hs;
        if (stop_hs == 16) begin
            m_ready = 1'b0;
            #1;
            done_next   = (done === 1'b1);
            valid_after = (m_valid === 1'b1);
            if (done === 1'b1) done_count++;
            if (fifo_en === 1'b1) en_bad++;
            @(negedge clk);
            #1;
            if (done === 1'b1) done_count++;
            if (fifo_en === 1'b1) en_bad++;
        end
        $display("job sh=%0d mode=%0d rows=%0d fifo_en=%0d done=%0d", sh, mode, obs_n, en_count, done_count);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; m_ready = 1'b1; shift_amt = 4'd5;
        fill_random();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_en got %b exp 0", fifo_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 128'd0) begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        start = 1'b0; m_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_full_throughput();
        logic [127:0] exp_row;
        logic [7:0]   rb;
        for (int r = 0; r < 16; r++)
            for (int l = 0; l < 16; l++)
                fifo_mem[r][20*l +: 20] = 20'(r * 256);
        run_job(8, 0, -1, 0, 16);
        checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL v1_rows got %0d exp 16", obs_n); end
        for (int r = 0; r < obs_n; r++) begin
            rb = 8'(r);
            exp_row = {16{rb}};
            checks++; if (obs_data[r] !== exp_row) begin errors++; $display("FAIL v1_row%0d got %h exp %h", r, obs_data[r], exp_row); end
            checks++; if (obs_last[r] != (r == 15)) begin errors++; $display("FAIL v1_last%0d got %0d exp %0d", r, obs_last[r], (r == 15)); end
        end
        checks++; if (valid_cycles != 16) begin errors++; $display("FAIL v1_valid_cycles got %0d exp 16", valid_cycles); end
        checks++; if (!done_next) begin errors++; $display("FAIL v1_done_next got 0 exp 1"); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL v1_done_count got %0d exp 1", done_count); end
        checks++; if (en_count != 16) begin errors++; $display("FAIL v1_fifo_en got %0d exp 16", en_count); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL v1_fifo_en_bad got %0d exp 0", en_bad); end
        checks++; if (valid_after) begin errors++; $display("FAIL v1_valid_after got 1 exp 0"); end
    endtask

    task automatic test_saturation();
        fill_random();
        fifo_mem[0][19:0]  = 20'h7FFFF;
        fifo_mem[0][39:20] = 20'h80000;
        fifo_mem[0][59:40] = 20'd300;
        fifo_mem[0][79:60] = -20'sd300;
        run_job(0, 2, -1, 0, 16);
        checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL v2_rows got %0d exp 16", obs_n); end
        checks++; if (obs_data[0][31:0] !== 32'h807F807F) begin errors++; $display("FAIL v2_sat got %h exp 807f807f", obs_data[0][31:0]); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], 0)) begin errors++; $display("FAIL v2_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], 0)); end
        end
    endtask

    task automatic test_floor();
        fill_random();
        fifo_mem[0][19:0]  = -20'sd5;
        fifo_mem[0][39:20] = 20'd5;
        run_job(1, 0, -1, 0, 16);
        checks++; if (obs_data[0][15:0] !== 16'h02FD) begin errors++; $display("FAIL v3_floor got %h exp 02fd", obs_data[0][15:0]); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], 1)) begin errors++; $display("FAIL v3_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], 1)); end
        end
    endtask

    task automatic test_backpressure();
        int sh;
        fill_random();
        sh = $urandom_range(0, 15);
        run_job(sh, 1, -1, 0, 16);
        checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL v4_rows got %0d exp 16", obs_n); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL v4_stall_change got %0d exp 0", stall_viol); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL v4_fifo_en_bad got %0d exp 0", en_bad); end
        checks++; if (en_count != 16) begin errors++; $display("FAIL v4_fifo_en got %0d exp 16", en_count); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL v4_done_count got %0d exp 1", done_count); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], sh)) begin errors++; $display("FAIL v4_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], sh)); end
        end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_job(8, 0, 5, 3, 16);
        checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL v5_rows got %0d exp 16", obs_n); end
        checks++; if (en_count != 16) begin errors++; $display("FAIL v5_fifo_en got %0d exp 16", en_count); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL v5_fifo_en_bad got %0d exp 0", en_bad); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL v5_done_count got %0d exp 1", done_count); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], 8)) begin errors++; $display("FAIL v5_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], 8)); end
        end
    endtask

    task automatic test_reset_mid_job();
        int done_seen;
        fill_random();
        run_job(8, 0, -1, 0, 8);
        checks++; if (obs_n != 8) begin errors++; $display("FAIL v6_partial_rows got %0d exp 8", obs_n); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], 8)) begin errors++; $display("FAIL v6_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], 8)); end
        end
        reset_n = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++; if (fifo_en !== 1'b0) begin errors++; $display("FAIL v6_fifo_en_in_reset got %b exp 0", fifo_en); end
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b0;
        #1;
        checks++; if ({m_valid, m_last, busy, done} !== 4'b0000 || m_data !== 128'd0)
            begin errors++; $display("FAIL v6_outputs got v%b l%b b%b d%b data %h exp all 0", m_valid, m_last, busy, done, m_data); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL v6_no_done got %0d exp 0", done_seen); end
        fill_random();
        run_job(8, 2, -1, 0, 16);
        checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL v6_fresh_rows got %0d exp 16", obs_n); end
        checks++; if (en_count != 16) begin errors++; $display("FAIL v6_fresh_fifo_en got %0d exp 16", en_count); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL v6_fresh_done got %0d exp 1", done_count); end
        for (int r = 0; r < obs_n; r++) begin
            checks++; if (obs_data[r] !== model_row(fifo_mem[r], 8)) begin errors++; $display("FAIL v6_fresh_row%0d got %h exp %h", r, obs_data[r], model_row(fifo_mem[r], 8)); end
        end
    endtask

    task automatic test_random_jobs();
        int sh;
        for (int j = 0; j < 6; j++) begin
            fill_random();
            sh = $urandom_range(0, 15);
            run_job(sh, 2, -1, 0, 16);
            checks++; if (timeout || obs_n != 16) begin errors++; $display("FAIL rnd%0d_rows got %0d exp 16", j, obs_n); end
            checks++; if (en_count != 16 || en_bad != 0) begin errors++; $display("FAIL rnd%0d_fifo_en got %0d bad %0d exp 16 bad 0", j, en_count, en_bad); end
            checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd%0d_stall got %0d exp 0", j, stall_viol); end
            checks++; if (!done_next || done_count != 1) begin errors++; $display("FAIL rnd%0d_done got next %0d count %0d exp 1 1", j, done_next, done_count); end
            for (int r = 0; r < obs_n; r++) begin
                checks++; if (obs_data[r] !== model_row(fifo_mem[r], sh)) begin errors++; $display("FAIL rnd%0d_row%0d got %h exp %h", j, r, obs_data[r], model_row(fifo_mem[r], sh)); end
                checks++; if (obs_last[r] != (r == 15)) begin errors++; $display("FAIL rnd%0d_last%0d got %0d exp %0d", j, r, obs_last[r], (r == 15)); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        shift_amt = 4'd0;
        m_ready = 1'b0;
        test_reset();
        test_full_throughput();
        test_saturation();
        test_floor();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_job();
        test_random_jobs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
